// File: rtl/muldiv_pkg.sv
// Package: muldiv_pkg
// Shared definitions for the iterative multiply/divide unit:
//   op_e    - operation codes presented on the 3-bit op port
//   state_e - sequencing states of muldiv_unit
//   is_arith_op / is_signed_op / is_div_op - small decode helpers
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    // True for the four ops that run through the iterative datapath.
    function automatic logic is_arith_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// Module: muldiv_step
// One combinational radix-2 iteration shared by multiply and divide.
//   is_div  in  select restoring-divide step (1) or shift-add multiply step (0)
//   m       in  multiplicand (mul) or divisor (div) magnitude
//   hi_in   in  upper accumulator half: partial product / partial remainder
//   lo_in   in  lower accumulator half: multiplier bits / dividend-quotient bits
//   hi_out  out upper accumulator after the step
//   lo_out  out lower accumulator after the step
// Multiply: add m when the current multiplier LSB is set, then shift the
//   whole {hi,lo} pair right by one; after WIDTH steps {hi,lo} is the product.
// Divide: shift the next dividend bit into the remainder, trial-subtract m,
//   keep the difference when it does not borrow and shift the quotient bit
//   into lo; after WIDTH steps lo is the quotient and hi the remainder.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             borrow;
    logic             unused_diff_msb;

    // A non-borrowing difference is below m, so bit WIDTH is always zero there.
    assign unused_diff_msb = diff[WIDTH];

    always_comb begin
        sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, m} : '0);
        shifted = {hi_in, lo_in[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, m};
        borrow  = diff[WIDTH+1];
        if (is_div) begin
            hi_out = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            lo_out = {lo_in[WIDTH-2:0], ~borrow};
        end else begin
            hi_out = sum[WIDTH:1];
            lo_out = {sum[0], lo_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Module: muldiv_unit
// Iterative multiply/divide unit owning the HI/LO register pair.
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   start  in   launch op (accepted only while not busy and not flushing)
//   op     in   operation code (muldiv_pkg::op_e)
//   a      in   rs operand: multiplicand / dividend / MTHI,MTLO data
//   b      in   rt operand: multiplier / divisor
//   flush  in   abort the in-flight op; hi/lo keep their old values
//   busy   out  op in flight
//   done   out  one-cycle pulse after hi/lo were written by MULT/DIV
//   hi     out  HI register (product high half / remainder)
//   lo     out  LO register (product low half / quotient)
// Sequence: IDLE -> CALC (WIDTH/UNROLL cycles) -> FIX (1 cycle) -> IDLE.
// Signed ops iterate on magnitudes and apply the sign correction in FIX.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int ITER  = WIDTH / UNROLL;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             is_div_q, is_div_d;
    logic             neg_p_q, neg_p_d;     // negate product / quotient
    logic             neg_r_q, neg_r_d;     // negate remainder (sign of dividend)
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Unrolled step chain: stage g feeds stage g+1 within one clock.
    logic [WIDTH-1:0] chain_hi [UNROLL+1];
    logic [WIDTH-1:0] chain_lo [UNROLL+1];

    assign chain_hi[0] = acc_hi_q;
    assign chain_lo[0] = acc_lo_q;

    for (genvar g = 0; g < UNROLL; g++) begin : g_step
        muldiv_step #(.WIDTH(WIDTH)) u_step (
            .is_div (is_div_q),
            .m      (m_q),
            .hi_in  (chain_hi[g]),
            .lo_in  (chain_lo[g]),
            .hi_out (chain_hi[g+1]),
            .lo_out (chain_lo[g+1])
        );
    end

    // Operand magnitudes and sign flags for launch.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        a_neg = is_signed_op(op) && a[WIDTH-1];
        b_neg = is_signed_op(op) && b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // Sign-corrected results, consumed in FIX.
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    always_comb begin
        prod_raw = {acc_hi_q, acc_lo_q};
        prod_fix = neg_p_q ? -prod_raw : prod_raw;
        quot_fix = neg_p_q ? -acc_lo_q : acc_lo_q;
        rem_fix  = neg_r_q ? -acc_hi_q : acc_hi_q;
        // Divide by zero: magnitude arithmetic already leaves |a| in the
        // remainder (sign-fixed back to a); the quotient is forced to all ones.
        if (div_zero_q) begin
            quot_fix = '1;
        end
    end

    always_comb begin
        // NOTE: every *_d defaults to its *_q first so no path through the
        // case below can leave a variable unassigned and infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        m_d        = m_q;
        is_div_d   = is_div_q;
        neg_p_d    = neg_p_q;
        neg_r_d    = neg_r_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // flush outranks start, so a squashed instruction never launches.
                if (start && !flush) begin
                    if (is_arith_op(op)) begin
                        state_d    = ST_CALC;
                        busy_d     = 1'b1;
                        cnt_d      = CNT_LAST;
                        is_div_d   = is_div_op(op);
                        neg_p_d    = a_neg ^ b_neg;
                        neg_r_d    = a_neg;
                        div_zero_d = is_div_op(op) && (b == '0);
                        acc_hi_d   = '0;
                        if (is_div_op(op)) begin
                            acc_lo_d = a_mag;
                            m_d      = b_mag;
                        end else begin
                            acc_lo_d = b_mag;
                            m_d      = a_mag;
                        end
                    end else if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end

            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    acc_hi_d = chain_hi[UNROLL];
                    acc_lo_d = chain_lo[UNROLL];
                    if (cnt_q == '0) begin
                        state_d = ST_FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end

            ST_FIX: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if (!flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its *_d value from before this edge, independent of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            m_q        <= '0;
            is_div_q   <= 1'b0;
            neg_p_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            m_q        <= m_d;
            is_div_q   <= is_div_d;
            neg_p_q    <= neg_p_d;
            neg_r_q    <= neg_r_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
